// File: rtl/obi_slice_pkg.sv
// Shared types and configuration for the OBI pipeline slice.
//   obi_cfg_t / ObiDefaultConfig : bus configuration (rready usage, integrity).
//   obi_a_chan_t / obi_r_chan_t  : A- and R-channel payloads, stored in the
//                                  slice buffers.
//   obi_req_t / obi_rsp_t        : full request/response bundles, for code
//                                  that carries the link as structs.
// Each buffer in the slice is 2 entries deep (head + skid). The depth is
// fixed and is not a parameter.
package obi_slice_pkg;

  typedef struct packed {
    logic UseRReady;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, Integrity: 1'b0};

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiIdW   = 2;

  typedef struct packed {
    logic [ObiAddrW-1:0]   addr;
    logic                  we;
    logic [ObiDataW/8-1:0] be;
    logic [ObiDataW-1:0]   wdata;
    logic [ObiIdW-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [ObiDataW-1:0] rdata;
    logic [ObiIdW-1:0]   rid;
    logic                err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/obi_slice_if.sv
// One OBI link, with both the request half and the response half.
//   master : the manager side. It drives req, a and rready. It receives gnt,
//            rvalid and r.
//   slave  : the subordinate side. It receives req, a and rready. It drives
//            gnt, rvalid and r.
interface obi_slice_if;
  import obi_slice_pkg::*;

  logic        req;
  logic        gnt;
  obi_a_chan_t a;
  logic        rvalid;
  logic        rready;
  obi_r_chan_t r;

  modport master (output req, a, rready, input gnt, rvalid, r);
  modport slave  (input req, a, rready, output gnt, rvalid, r);
endinterface

// File: rtl/obi_slice_spill.sv
// A 2-entry spill register: a head register plus a skid register.
//   clk_i, rst_ni       : clock, and asynchronous active-low reset
//   valid_i/ready_o/data_i : upstream push side. ready_o comes only from flops.
//   valid_o/ready_i/data_o : downstream pop side. It is driven from the head
//                            register.
// The buffer gives full throughput. The head does not change while it is
// valid and not popped, so data_o stays stable under backpressure.
module obi_slice_spill #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  logic  head_vld_q, skid_vld_q;
  data_t head_q, skid_q;
  logic  push, pop;

  // Accept whenever the skid register is free. When the head is busy, the
  // new beat lands in the skid register, so there is no combinational path
  // from ready_i to ready_o.
  assign ready_o = !skid_vld_q;
  assign valid_o = head_vld_q;
  assign data_o  = head_q;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (pop) begin
      // A full buffer never pushes (ready_o=0). So on a pop, either the skid
      // entry moves up, or a new beat goes straight into the head.
      if (skid_vld_q) begin
        head_q     <= skid_q;
        skid_vld_q <= 1'b0;
      end else if (push) begin
        head_q <= data_i;
      end else begin
        head_vld_q <= 1'b0;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_q     <= data_i;
        head_vld_q <= 1'b1;
      end else begin
        skid_q     <= data_i;
        skid_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_slice.sv
// A registered OBI pipeline stage. It sits on one manager port of the OBI
// demultiplexer.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   sbr_port : link from the upstream manager. The slice is the subordinate
//              on this link.
//   mgr_port : link to the downstream subordinate. The slice is the manager
//              on this link.
// The req/a and gnt paths always pass through a 2-entry spill register.
// Requests granted in cycle N appear downstream in cycle N+1.
// Optional macro OBI_SLICE_RSP_CUT_EN: the R path also goes through a
// spill register. This adds one cycle of response latency. Without the
// macro, the R path is combinational.
// The slice adds no limit on outstanding transactions. It keeps strict order.
module obi_slice
  import obi_slice_pkg::*;
#(
  parameter obi_cfg_t ObiCfg = ObiDefaultConfig
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  obi_slice_if.slave  sbr_port,
  obi_slice_if.master mgr_port
);

  if (ObiCfg.Integrity) begin : g_integrity
    $fatal(1, "obi_slice: Integrity unimplemented");
  end

  // Without rready, upstream accepts every response beat.
  logic rsp_accept;
  assign rsp_accept = ObiCfg.UseRReady ? sbr_port.rready : 1'b1;

  obi_slice_spill #(.data_t(obi_a_chan_t)) i_a_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (sbr_port.req),
    .ready_o (sbr_port.gnt),
    .data_i  (sbr_port.a),
    .valid_o (mgr_port.req),
    .ready_i (mgr_port.gnt),
    .data_o  (mgr_port.a)
  );

`ifdef OBI_SLICE_RSP_CUT_EN
  logic rsp_buf_ready;

  // When rready is not used, rsp_accept is tied high. The skid register
  // then never fills, and only the head register acts as a stage.
  obi_slice_spill #(.data_t(obi_r_chan_t)) i_r_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (mgr_port.rvalid),
    .ready_o (rsp_buf_ready),
    .data_i  (mgr_port.r),
    .valid_o (sbr_port.rvalid),
    .ready_i (rsp_accept),
    .data_o  (sbr_port.r)
  );

  assign mgr_port.rready = ObiCfg.UseRReady ? rsp_buf_ready : 1'b1;
`else
  assign sbr_port.rvalid = mgr_port.rvalid;
  assign sbr_port.r      = mgr_port.r;
  // rready is tied high when the bus does not use it.
  assign mgr_port.rready = rsp_accept;
`endif

endmodule
